// File: rtl/rr_plogb_flow_ctrl_pkg.sv
// Shared types for the packed logging-bus flow controller: FSM states and a saturating add.
// Combinational helpers only; no latency, no backpressure.
package rr_plogb_flow_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        DRAIN      = 3'd2,
        WAIT_EMPTY = 3'd3,
        DONE       = 3'd4
    } state_t;

    // Sum clamps to maxv; callers pass the all-ones value of their own width.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] maxv);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, maxv}) ? maxv : s[63:0];
    endfunction

endpackage

// File: rtl/rr_plogb_flow_ctrl_if.sv
// Packed-bus side of the flow controller: beat push/length, FIFO pop and almful back-pressure.
// Wires only; almful is registered inside the controller.
interface rr_plogb_flow_ctrl_if #(
    parameter int LEN_WIDTH = 10
);
    logic                 plogb_valid;
    logic [LEN_WIDTH-1:0] plogb_len;
    logic                 fifo_pop;
    logic                 logb_almful;

    modport master (
        output plogb_valid,
        output plogb_len,
        output fifo_pop,
        input  logb_almful
    );

    modport slave (
        input  plogb_valid,
        input  plogb_len,
        input  fifo_pop,
        output logb_almful
    );
endinterface

// File: rtl/rr_sat_counter.sv
// Saturating statistics counter with synchronous clear; clear wins over a same-cycle increment.
// One-cycle update latency, never stalls.
module rr_sat_counter
    import rr_plogb_flow_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [INC_WIDTH-1:0] inc_val,
    output logic [WIDTH-1:0]     cnt
);
    localparam logic [63:0] MAXV = (WIDTH >= 64) ? '1 : ((64'd1 << WIDTH) - 64'd1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= WIDTH'(sat_add(64'(cnt), 64'(inc_val), MAXV));
        end
    end
endmodule

// File: rtl/rr_plogb_flow_ctrl.sv
// Trace-FIFO occupancy tracker and enable/flush sequencer for the packed logging-bus tree.
// logb_almful is registered (1 cycle after the push that crosses the threshold); flush drains to empty.
module rr_plogb_flow_ctrl
    import rr_plogb_flow_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int PIPE_LAT   = 4,
    parameter int MARGIN     = 2,
    parameter int LEN_WIDTH  = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            flush_req,
    rr_plogb_flow_ctrl_if.slave             bus,
    input  logic                            stat_clr,
    output logic                            flush_done,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] occ,
    output logic                            overflow_err,
    output logic                            underflow_err,
    output logic                            late_valid_err,
    output logic [CNT_WIDTH-1:0]            beat_cnt,
    output logic [CNT_WIDTH-1:0]            bit_cnt,
    output logic [CNT_WIDTH-1:0]            stall_cnt
);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int THRESH = FIFO_DEPTH - PIPE_LAT - MARGIN;
    localparam int TMR_W  = $clog2(PIPE_LAT + 1);
    localparam int HI_W   = $clog2(PIPE_LAT + 2);

    localparam logic [OCC_W-1:0] DEPTH_V  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] THRESH_V = OCC_W'(THRESH);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PIPE_LAT);
    localparam logic [HI_W-1:0]  HI_MAX   = HI_W'(PIPE_LAT + 1);

    generate
        if (THRESH <= 0) begin : g_bad_thresh
            $error("rr_plogb_flow_ctrl: FIFO_DEPTH too small for PIPE_LAT + MARGIN");
        end
    endgenerate

    state_t             state;
    logic               alm_q;
    logic [TMR_W-1:0]   tmr;
    logic [HI_W-1:0]    hi_cnt;
    logic [OCC_W-1:0]   occ_nxt;
    logic               ovf, unf, accept, late_hit;
    logic               push, pop;

    assign push            = bus.plogb_valid;
    assign pop             = bus.fifo_pop;
    assign bus.logb_almful = alm_q;
    assign busy            = (state != IDLE);

    always_comb begin
        occ_nxt = occ;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (push && !pop) begin
            if (occ == DEPTH_V) ovf = 1'b1;
            else                occ_nxt = occ + OCC_W'(1);
        end else if (pop && !push) begin
            if (occ == '0) unf = 1'b1;
            else           occ_nxt = occ - OCC_W'(1);
        end
    end

    assign accept = push && !ovf;
    // hi_cnt counts earlier almful cycles, so a push on the rising cycle sees zero.
    assign late_hit = push && ((state == IDLE) || (alm_q && (hi_cnt == HI_MAX)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alm_q      <= 1'b1;
            flush_done <= 1'b0;
            tmr        <= '0;
        end else begin
            alm_q      <= 1'b1;
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        alm_q <= (occ_nxt >= THRESH_V);
                    end
                end
                RUN: begin
                    if (flush_req || !enable) begin
                        state <= DRAIN;
                        tmr   <= TMR_LOAD;
                    end else begin
                        alm_q <= (occ_nxt >= THRESH_V);
                    end
                end
                DRAIN: begin
                    if (push) begin
                        tmr <= TMR_LOAD;
                    end else if (tmr <= TMR_W'(1)) begin
                        tmr   <= '0;
                        state <= WAIT_EMPTY;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                WAIT_EMPTY: begin
                    if (occ == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (enable) begin
                        state <= RUN;
                        alm_q <= (occ_nxt >= THRESH_V);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ            <= '0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
            late_valid_err <= 1'b0;
            hi_cnt         <= '0;
        end else begin
            occ <= occ_nxt;
            if (ovf)      overflow_err   <= 1'b1;
            if (unf)      underflow_err  <= 1'b1;
            if (late_hit) late_valid_err <= 1'b1;
            if (!alm_q)                hi_cnt <= '0;
            else if (hi_cnt != HI_MAX) hi_cnt <= hi_cnt + HI_W'(1);
        end
    end

    rr_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (stat_clr),
        .inc     (accept),
        .inc_val (1'b1),
        .cnt     (beat_cnt)
    );

    rr_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(LEN_WIDTH)) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (stat_clr),
        .inc     (accept),
        .inc_val (bus.plogb_len),
        .cnt     (bit_cnt)
    );

    rr_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (stat_clr),
        .inc     ((state == RUN) && alm_q),
        .inc_val (1'b1),
        .cnt     (stall_cnt)
    );
endmodule

// File: tb/tb_rr_plogb_flow_ctrl.sv
// Directed plus randomized bench for rr_plogb_flow_ctrl against a cycle-level behavioural model.
// 12-bit statistics counters so saturation is reachable within the random phase.
module tb_rr_plogb_flow_ctrl;
    localparam int CW   = 12;
    localparam int CMAX = (1 << CW) - 1;
    localparam int DEP  = 64;
    localparam int LAT  = 4;
    localparam int THR  = 58;

    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_WAIT = 3, S_DONE = 4;

    logic          clk = 1'b0;
    logic          rst, enable, flush_req, stat_clr;
    logic          flush_done, busy, overflow_err, underflow_err, late_valid_err;
    logic [6:0]    occ;
    logic [CW-1:0] beat_cnt, bit_cnt, stall_cnt;

    rr_plogb_flow_ctrl_if #(.LEN_WIDTH(10)) bus_if ();

    rr_plogb_flow_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .flush_req      (flush_req),
        .bus            (bus_if),
        .stat_clr       (stat_clr),
        .flush_done     (flush_done),
        .busy           (busy),
        .occ            (occ),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err),
        .late_valid_err (late_valid_err),
        .beat_cnt       (beat_cnt),
        .bit_cnt        (bit_cnt),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int m_st, m_occ, m_alm, m_done, m_quiet, m_hi;
    int m_ovf, m_unf, m_late, m_beat, m_bit, m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model(input bit v, input int len, input bit p, input bit fl, input bit sc);
        int nocc, nst;
        bit ovf_now, unf_now, acc;
        if (rst) begin
            m_st = S_IDLE; m_alm = 1; m_done = 0; m_occ = 0; m_quiet = 0; m_hi = 0;
            m_ovf = 0; m_unf = 0; m_late = 0; m_beat = 0; m_bit = 0; m_stall = 0;
            return;
        end
        ovf_now = v && !p && (m_occ == DEP);
        unf_now = p && !v && (m_occ == 0);
        acc     = v && !ovf_now;
        nocc    = m_occ;
        if (v && !p && !ovf_now) nocc++;
        if (p && !v && !unf_now) nocc--;
        if (ovf_now) m_ovf = 1;
        if (unf_now) m_unf = 1;
        if (v && (m_st == S_IDLE || (m_alm == 1 && m_hi > LAT))) m_late = 1;
        if (sc) begin
            m_beat = 0; m_bit = 0; m_stall = 0;
        end else begin
            if (acc) begin
                m_beat = sat(m_beat + 1);
                m_bit  = sat(m_bit + len);
            end
            if (m_st == S_RUN && m_alm == 1) m_stall = sat(m_stall + 1);
        end
        m_hi = (m_alm == 1) ? ((m_hi + 1 > LAT + 1) ? LAT + 1 : m_hi + 1) : 0;
        nst = m_st;
        case (m_st)
            S_IDLE:  if (enable) nst = S_RUN;
            S_RUN:   if (fl || !enable) begin nst = S_DRAIN; m_quiet = LAT; end
            S_DRAIN: begin
                if (v) m_quiet = LAT;
                else begin
                    m_quiet--;
                    if (m_quiet == 0) nst = S_WAIT;
                end
            end
            S_WAIT:  if (m_occ == 0) nst = S_DONE;
            default: nst = enable ? S_RUN : S_IDLE;
        endcase
        m_alm  = (nst == S_RUN) ? int'(nocc >= THR) : 1;
        m_done = int'(nst == S_DONE);
        m_occ  = nocc;
        m_st   = nst;
    endtask

    task automatic check_all();
        chk("occ", 64'(occ), 64'(m_occ));
        chk("almful", 64'(bus_if.logb_almful), 64'(m_alm));
        chk("flush_done", 64'(flush_done), 64'(m_done));
        chk("busy", 64'(busy), 64'(m_st != S_IDLE));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("underflow_err", 64'(underflow_err), 64'(m_unf));
        chk("late_valid_err", 64'(late_valid_err), 64'(m_late));
        chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
        chk("bit_cnt", 64'(bit_cnt), 64'(m_bit));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    endtask

    task automatic cyc(input bit v, input int len, input bit p, input bit fl, input bit sc);
        @(negedge clk);
        bus_if.plogb_valid = v;
        bus_if.plogb_len   = 10'(len);
        bus_if.fifo_pop    = p;
        flush_req          = fl;
        stat_clr           = sc;
        @(posedge clk);
        model(v, len, p, fl, sc);
        #1;
        check_all();
    endtask

    initial begin
        int s0, done_idx, done_cnt;
        rst = 1'b1; enable = 1'b0; flush_req = 1'b0; stat_clr = 1'b0;
        bus_if.plogb_valid = 1'b0; bus_if.plogb_len = '0; bus_if.fifo_pop = 1'b0;

        // Reset values
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_almful", 64'(bus_if.logb_almful), 64'd1);
        chk("rst_occ", 64'(occ), 64'd0);
        rst = 1'b0;
        enable = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Fill to threshold; almful rises the cycle after the 58th push
        for (int i = 0; i < 58; i++) begin
            cyc(1, int'($urandom_range(0, 1023)), 0, 0, 0);
            if (i == 56) chk("alm_before_thresh", 64'(bus_if.logb_almful), 64'd0);
        end
        chk("alm_at_thresh", 64'(bus_if.logb_almful), 64'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        chk("late_at_lat", 64'(late_valid_err), 64'd0);
        cyc(1, 7, 0, 0, 0);
        chk("late_past_lat", 64'(late_valid_err), 64'd1);
        chk("occ_60", 64'(occ), 64'd60);
        chk("no_ovf", 64'(overflow_err), 64'd0);

        // Push+pop at threshold keeps occ and counts stalls
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        s0 = m_stall;
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0);
        chk("occ_hold_58", 64'(occ), 64'd58);
        chk("stall_plus10", 64'(stall_cnt), 64'(s0 + 10));

        // Underflow and overflow boundaries
        for (int i = 0; i < 58; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("unf_set", 64'(underflow_err), 64'd1);
        chk("unf_occ0", 64'(occ), 64'd0);
        for (int i = 0; i < 64; i++) cyc(1, 3, 0, 0, 0);
        cyc(1, 3, 0, 0, 0);
        chk("ovf_set", 64'(overflow_err), 64'd1);
        chk("ovf_occ64", 64'(occ), 64'd64);
        for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0, 0);

        // Flush with late pushes in DRAIN
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 9, 1, 0, 0);
        cyc(1, 9, 1, 0, 0);
        done_idx = -1; done_cnt = 0;
        for (int k = 4; k < 30; k++) begin
            cyc(0, 0, m_occ > 0, 0, 0);
            if (flush_done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = k;
            end
        end
        chk("flush_done_once", 64'(done_cnt), 64'd1);
        chk("flush_done_time", 64'(done_idx), 64'd8);
        chk("back_to_run", 64'(busy), 64'd1);

        // Bit/beat accounting and stat_clr priority
        cyc(0, 0, 0, 0, 1);
        cyc(1, 100, 1, 0, 0);
        cyc(1, 200, 1, 0, 0);
        cyc(1, 37, 1, 0, 0);
        chk("bit_337", 64'(bit_cnt), 64'd337);
        chk("beat_3", 64'(beat_cnt), 64'd3);
        cyc(1, 55, 1, 0, 1);
        chk("clr_beat", 64'(beat_cnt), 64'd0);
        chk("clr_bit", 64'(bit_cnt), 64'd0);

        // Randomized traffic from a clean reset
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 19) != 0);
            cyc($urandom_range(0, 1), int'($urandom_range(0, 1023)), $urandom_range(0, 1),
                $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end

        // Reset in WAIT_EMPTY
        enable = 1'b1;
        for (int i = 0; i < 60 && !(m_st == S_RUN && m_occ == 0); i++) cyc(0, 0, m_occ > 0, 0, 0);
        cyc(1, 5, 0, 0, 0);
        cyc(1, 5, 0, 0, 0);
        cyc(1, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0);
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_occ3", 64'(occ), 64'd3);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rst_idle", 64'(busy), 64'd0);
        chk("rst_alm1", 64'(bus_if.logb_almful), 64'd1);
        rst = 1'b0; enable = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_no_done", 64'(flush_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
